cu_sequencer: RTL and testbench
===============================

Name: cu_sequencer

Overview:
- Multi-cycle control unit that drives the ALU.
- Fetches each instruction word over a req/ack instruction-memory handshake and holds it in an instruction register for the external decoder.
- Evaluates the 4-bit condition field against the architectural NZCV flags and issues a single-cycle cu_execute strobe.
- Commits the results: register-file write, link-register write, flag update and PC update. Sits between instruction memory, the decoder and the ALU/register file.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
OP_W, 5, width of the decoded instruction-class code (the `Defines.v` encodings: MOV_LAS, B, BX, ERET)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address (= pc)
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
ir  out  32  instruction register, to decoder
dec_op  in  OP_W  decoded instruction class (combinational from ir)
dec_valid  in  1  decoder recognised ir
dec_cond  in  4  condition field
dec_s  in  1  set-flags bit
dec_l  in  1  link bit
alu_n, alu_z, alu_c, alu_v  in  1 each  ALU flag outputs
alu_pc  in  32  ALU-computed branch target (w_PC / Rd of BX)
cu_execute  out  1  ALU execute strobe
instruction  out  OP_W  registered dec_op, to ALU
rf_we  out  1  destination-register write enable
lr_we  out  1  link-register write enable
pc  out  32  program counter
flag_n, flag_z, flag_c, flag_v  out  1 each  architectural flags, to ALU in_n/z/c/v
trap  out  1  undefined instruction seen; core halted
state_o  out  3  current FSM state, debug

Behaviour:
- Reset (asynchronous, any state, including mid-fetch): state=FETCH, pc=RESET_PC, ir=0, instruction=0, flags=0, trap=0. All strobes (cu_execute, rf_we, lr_we) are 0. imem_req=0 during reset and is asserted on the first clock after release.
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3, TRAP=4.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until imem_ack.
  - On the imem_ack cycle: ir<=imem_rdata, go to DECODE. imem_req drops the following cycle.
  - An ack with no request outstanding is ignored.
- DECODE (1 cycle):
  - If !dec_valid: trap<=1, go to TRAP.
  - Otherwise latch instruction<=dec_op and evaluate cond_pass:
    - 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V
    - 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V)
    - 1110 always; 1111 never
  - cond_pass=1: go to EXECUTE.
  - cond_pass=0: pc<=pc+4, go to FETCH. No strobes, flags unchanged.
- EXECUTE (1 cycle): cu_execute=1; ALU outputs settle. Go to WRITEBACK.
- WRITEBACK (1 cycle):
  - MOV_LAS: rf_we=1. If dec_s, flags<=alu_n/z/c/v (alu_v is taken as-is). pc<=pc+4.
  - B or BX: lr_we=dec_l. pc<=alu_pc. Flags unchanged.
  - ERET: pc<=alu_pc.
  - Any other valid op: pc<=pc+4, no writes.
  - Go to FETCH.
- TRAP: terminal until reset. No further fetches; all strobes 0; pc holds the address of the faulting instruction.
- Timing:
  - cu_execute, rf_we and lr_we are registered-state decodes, each exactly 1 cycle wide per instruction.
  - Minimum latency per executed instruction: 4 cycles (ack in the first FETCH cycle).
  - Minimum latency per condition-failed instruction: 2 cycles.
- pc arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- ir, dec_* and flags are sampled only in the states named above; decoder inputs changing in other states have no effect.

Test Plan:
- Reset then 3-cycle ack delay: imem_req=1 with imem_addr=0 held for 3 cycles. On ack with ir=32'hE1A0_1002 (MOV_LAS, AL), cu_execute pulses exactly 1 cycle, rf_we pulses the next cycle, then pc=4.
- Flag set: MOV_LAS with dec_s=1 and ALU flags Z=1,C=1 -> flag_z=1, flag_c=1 after WRITEBACK. Same op with dec_s=0 -> flags unchanged.
- Condition fail: flag_z=0, cond=0000 (EQ) -> no cu_execute, pc 8->12 two cycles after ack. Cond=1111 never executes; cond=1110 always does.
- Branch with link: B, dec_l=1, alu_pc=32'h0000_0100, pc=32'h40 -> lr_we pulses 1 cycle, pc=32'h100, next imem_addr=32'h100. BX with dec_l=0 -> lr_we stays 0.
- Undefined: dec_valid=0 -> trap=1, state_o=4, imem_req stays 0 for 20 cycles, pc unchanged. Asserting rst clears trap and returns pc to RESET_PC.
- Async reset mid-EXECUTE: rst asserted between clock edges -> cu_execute drops immediately, no rf_we pulse, and pc and flags return to reset values.

Source files
------------

// File: rtl/cu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cu_sequencer
// Description : Multi-cycle control unit. Fetches over a req/ack handshake,
//               holds the instruction for the external decoder, evaluates the
//               NZCV condition, strobes the ALU and commits RF/LR/flags/PC.
// Revision    : 1.0 - initial release
// ============================================================================
module cu_sequencer #(
    parameter logic [31:0]   RESET_PC   = 32'h0000_0000,
    parameter int            OP_W       = 5,
    // Instruction-class encodings produced by the decoder
    parameter logic [OP_W-1:0] OP_MOV_LAS = OP_W'(1),
    parameter logic [OP_W-1:0] OP_B       = OP_W'(2),
    parameter logic [OP_W-1:0] OP_BX      = OP_W'(3),
    parameter logic [OP_W-1:0] OP_ERET    = OP_W'(4)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [31:0]     imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir,
    input  logic [OP_W-1:0] dec_op,
    input  logic            dec_valid,
    input  logic [3:0]      dec_cond,
    input  logic            dec_s,
    input  logic            dec_l,
    input  logic            alu_n,
    input  logic            alu_z,
    input  logic            alu_c,
    input  logic            alu_v,
    input  logic [31:0]     alu_pc,
    output logic            cu_execute,
    output logic [OP_W-1:0] instruction,
    output logic            rf_we,
    output logic            lr_we,
    output logic [31:0]     pc,
    output logic            flag_n,
    output logic            flag_z,
    output logic            flag_c,
    output logic            flag_v,
    output logic            trap,
    output logic [2:0]      state_o
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_TRAP      = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_started;   // low during reset so imem_req stays quiet
    logic [31:0]     r_pc;
    logic [31:0]     r_ir;
    logic [OP_W-1:0] r_instr;
    logic            r_n, r_z, r_c, r_v;
    logic            r_trap;

    logic            w_fetch_done;
    logic            w_cond_pass;
    logic            w_is_mov;
    logic            w_is_branch;
    logic            w_is_eret;
    logic [31:0]     w_pc_plus4;

    assign w_fetch_done = (r_state == S_FETCH) && r_started && imem_ack;
    assign w_is_mov     = (r_instr == OP_MOV_LAS);
    assign w_is_branch  = (r_instr == OP_B) || (r_instr == OP_BX);
    assign w_is_eret    = (r_instr == OP_ERET);
    assign w_pc_plus4   = r_pc + 32'd4;

    // Condition-code evaluation against the architectural flags
    always_comb begin
        w_cond_pass = 1'b0;
        case (dec_cond)
            4'b0000: w_cond_pass = r_z;
            4'b0001: w_cond_pass = !r_z;
            4'b0010: w_cond_pass = r_c;
            4'b0011: w_cond_pass = !r_c;
            4'b0100: w_cond_pass = r_n;
            4'b0101: w_cond_pass = !r_n;
            4'b0110: w_cond_pass = r_v;
            4'b0111: w_cond_pass = !r_v;
            4'b1000: w_cond_pass = r_c && !r_z;
            4'b1001: w_cond_pass = !r_c || r_z;
            4'b1010: w_cond_pass = (r_n == r_v);
            4'b1011: w_cond_pass = (r_n != r_v);
            4'b1100: w_cond_pass = !r_z && (r_n == r_v);
            4'b1101: w_cond_pass = r_z || (r_n != r_v);
            4'b1110: w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_fetch_done) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (!dec_valid)       w_next = S_TRAP;
                else if (w_cond_pass) w_next = S_EXECUTE;
                else                  w_next = S_FETCH;
            end
            S_EXECUTE:   w_next = S_WRITEBACK;
            S_WRITEBACK: w_next = S_FETCH;
            S_TRAP:      w_next = S_TRAP;
            default:     w_next = S_FETCH;
        endcase
    end

    // Datapath registers: IR, latched op, PC, flags, trap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_started <= 1'b0;
            r_pc      <= RESET_PC;
            r_ir      <= 32'h0;
            r_instr   <= '0;
            r_n       <= 1'b0;
            r_z       <= 1'b0;
            r_c       <= 1'b0;
            r_v       <= 1'b0;
            r_trap    <= 1'b0;
        end else begin
            r_started <= 1'b1;
            case (r_state)
                S_FETCH: begin
                    if (w_fetch_done) r_ir <= imem_rdata;
                end
                S_DECODE: begin
                    if (!dec_valid) begin
                        r_trap <= 1'b1;
                    end else begin
                        r_instr <= dec_op;
                        if (!w_cond_pass) r_pc <= w_pc_plus4;
                    end
                end
                S_WRITEBACK: begin
                    if (w_is_mov) begin
                        if (dec_s) begin
                            r_n <= alu_n;
                            r_z <= alu_z;
                            r_c <= alu_c;
                            r_v <= alu_v;
                        end
                        r_pc <= w_pc_plus4;
                    end else if (w_is_branch || w_is_eret) begin
                        r_pc <= alu_pc;
                    end else begin
                        r_pc <= w_pc_plus4;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes are pure decodes of the registered state
    assign imem_req    = (r_state == S_FETCH) && r_started;
    assign imem_addr   = r_pc;
    assign cu_execute  = (r_state == S_EXECUTE);
    assign rf_we       = (r_state == S_WRITEBACK) && w_is_mov;
    assign lr_we       = (r_state == S_WRITEBACK) && w_is_branch && dec_l;
    assign ir          = r_ir;
    assign instruction = r_instr;
    assign pc          = r_pc;
    assign flag_n      = r_n;
    assign flag_z      = r_z;
    assign flag_c      = r_c;
    assign flag_v      = r_v;
    assign trap        = r_trap;
    assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_cu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cu_sequencer
// Description : Directed self-checking bench for cu_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cu_sequencer;

    localparam int          OP_W     = 5;
    localparam logic [4:0]  C_MOV    = 5'd1;
    localparam logic [4:0]  C_B      = 5'd2;
    localparam logic [4:0]  C_BX     = 5'd3;
    localparam logic [4:0]  C_ERET   = 5'd4;
    localparam logic [4:0]  C_OTHER  = 5'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [4:0]  dec_op;
    logic        dec_valid;
    logic [3:0]  dec_cond;
    logic        dec_s;
    logic        dec_l;
    logic        alu_n, alu_z, alu_c, alu_v;
    logic [31:0] alu_pc;
    logic        cu_execute;
    logic [4:0]  instruction;
    logic        rf_we;
    logic        lr_we;
    logic [31:0] pc;
    logic        flag_n, flag_z, flag_c, flag_v;
    logic        trap;
    logic [2:0]  state_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cu_sequencer #(
        .RESET_PC   (32'h0000_0000),
        .OP_W       (OP_W),
        .OP_MOV_LAS (C_MOV),
        .OP_B       (C_B),
        .OP_BX      (C_BX),
        .OP_ERET    (C_ERET)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ir          (ir),
        .dec_op      (dec_op),
        .dec_valid   (dec_valid),
        .dec_cond    (dec_cond),
        .dec_s       (dec_s),
        .dec_l       (dec_l),
        .alu_n       (alu_n),
        .alu_z       (alu_z),
        .alu_c       (alu_c),
        .alu_v       (alu_v),
        .alu_pc      (alu_pc),
        .cu_execute  (cu_execute),
        .instruction (instruction),
        .rf_we       (rf_we),
        .lr_we       (lr_we),
        .pc          (pc),
        .flag_n      (flag_n),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .flag_v      (flag_v),
        .trap        (trap),
        .state_o     (state_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] flags4();
        return {28'h0, flag_n, flag_z, flag_c, flag_v};
    endfunction

    task automatic set_dec(input logic valid, input logic [4:0] op, input logic [3:0] cond,
                           input logic s, input logic l);
        dec_valid = valid;
        dec_op    = op;
        dec_cond  = cond;
        dec_s     = s;
        dec_l     = l;
    endtask

    task automatic set_alu(input logic [3:0] nzcv, input logic [31:0] tgt);
        {alu_n, alu_z, alu_c, alu_v} = nzcv;
        alu_pc = tgt;
    endtask

    // Starts at a FETCH negedge; waits, acks, ends at the DECODE negedge
    task automatic fetch(input logic [31:0] word, input int wait_cycles, input logic [31:0] addr);
        for (int i = 0; i < wait_cycles; i++) begin
            chk("fetch_req_wait", {31'h0, imem_req}, 32'd1);
            chk("fetch_addr_wait", imem_addr, addr);
            tick();
        end
        chk("fetch_req", {31'h0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, addr);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        chk("decode_state", {29'h0, state_o}, 32'd1);
        chk("decode_ir", ir, word);
        chk("decode_req_low", {31'h0, imem_req}, 32'd0);
    endtask

    // One complete instruction from a FETCH negedge to the next FETCH negedge
    task automatic exec_instr(input string tag, input logic [31:0] word, input logic [31:0] cur_pc,
                              input logic [4:0] op, input logic [3:0] cond,
                              input logic s, input logic l,
                              input logic [3:0] alu_nzcv, input logic [31:0] tgt,
                              input logic pass, input logic exp_rf, input logic exp_lr,
                              input logic [31:0] exp_pc, input logic [3:0] exp_flags);
        fetch(word, 0, cur_pc);
        set_dec(1'b1, op, cond, s, l);
        set_alu(alu_nzcv, tgt);
        chk({tag, "_dec_exe"}, {31'h0, cu_execute}, 32'd0);
        tick();
        if (pass) begin
            chk({tag, "_exe"}, {31'h0, cu_execute}, 32'd1);
            chk({tag, "_exe_instr"}, {27'h0, instruction}, {27'h0, op});
            chk({tag, "_exe_strobes"}, {30'h0, rf_we, lr_we}, 32'd0);
            // decoder inputs that are not sampled here must have no effect
            dec_valid = 1'b0;
            dec_cond  = 4'hF;
            dec_op    = 5'h1F;
            tick();
            chk({tag, "_wb_exe"}, {31'h0, cu_execute}, 32'd0);
            chk({tag, "_wb_rf"}, {31'h0, rf_we}, {31'h0, exp_rf});
            chk({tag, "_wb_lr"}, {31'h0, lr_we}, {31'h0, exp_lr});
            tick();
        end
        chk({tag, "_state"}, {29'h0, state_o}, 32'd0);
        chk({tag, "_pc"}, pc, exp_pc);
        chk({tag, "_addr"}, imem_addr, exp_pc);
        chk({tag, "_flags"}, flags4(), {28'h0, exp_flags});
        chk({tag, "_strobes_off"}, {29'h0, cu_execute, rf_we, lr_we}, 32'd0);
        set_dec(1'b1, 5'd0, 4'hE, 1'b0, 1'b0);
    endtask

    initial begin
        int bad;
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        set_dec(1'b1, 5'd0, 4'hE, 1'b0, 1'b0);
        set_alu(4'h0, 32'h0);
        tick();
        tick();

        // ---- reset state
        chk("rst_state", {29'h0, state_o}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_instr", {27'h0, instruction}, 32'h0);
        chk("rst_flags", flags4(), 32'h0);
        chk("rst_trap", {31'h0, trap}, 32'd0);
        chk("rst_req", {31'h0, imem_req}, 32'd0);
        chk("rst_strobes", {29'h0, cu_execute, rf_we, lr_we}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_req_before_clk", {31'h0, imem_req}, 32'd0);
        tick();

        // ---- first instruction with 3-cycle ack delay
        fetch(32'hE1A0_1002, 3, 32'h0);
        set_dec(1'b1, C_MOV, 4'hE, 1'b0, 1'b0);
        tick();
        chk("t1_exe", {31'h0, cu_execute}, 32'd1);
        chk("t1_exe_rf", {31'h0, rf_we}, 32'd0);
        chk("t1_instr", {27'h0, instruction}, {27'h0, C_MOV});
        tick();
        chk("t1_wb_exe", {31'h0, cu_execute}, 32'd0);
        chk("t1_wb_rf", {31'h0, rf_we}, 32'd1);
        chk("t1_wb_pc", pc, 32'h0);
        tick();
        chk("t1_rf_off", {31'h0, rf_we}, 32'd0);
        chk("t1_pc", pc, 32'h4);
        chk("t1_addr", imem_addr, 32'h4);
        chk("t1_req", {31'h0, imem_req}, 32'd1);

        // ---- conditions
        exec_instr("nv",    32'hF1A0_0000, 32'h04, C_MOV, 4'hF, 1'b0, 1'b0, 4'h0, 32'h0,
                   1'b0, 1'b0, 1'b0, 32'h08, 4'h0);
        exec_instr("eq_f",  32'h01A0_0000, 32'h08, C_MOV, 4'h0, 1'b0, 1'b0, 4'h0, 32'h0,
                   1'b0, 1'b0, 1'b0, 32'h0C, 4'h0);
        exec_instr("other", 32'hE000_0000, 32'h0C, C_OTHER, 4'hE, 1'b1, 1'b1, 4'hF, 32'h0,
                   1'b1, 1'b0, 1'b0, 32'h10, 4'h0);
        // ---- flag update
        exec_instr("mov_s", 32'hE1B0_0000, 32'h10, C_MOV, 4'hE, 1'b1, 1'b0, 4'b0110, 32'h0,
                   1'b1, 1'b1, 1'b0, 32'h14, 4'b0110);
        exec_instr("eq_t",  32'h01A0_0000, 32'h14, C_MOV, 4'h0, 1'b0, 1'b0, 4'b1001, 32'h0,
                   1'b1, 1'b1, 1'b0, 32'h18, 4'b0110);
        exec_instr("gt_f",  32'hC1A0_0000, 32'h18, C_MOV, 4'hC, 1'b0, 1'b0, 4'h0, 32'h0,
                   1'b0, 1'b0, 1'b0, 32'h1C, 4'b0110);
        exec_instr("ls_t",  32'h91A0_0000, 32'h1C, C_MOV, 4'h9, 1'b0, 1'b0, 4'h0, 32'h0,
                   1'b1, 1'b1, 1'b0, 32'h20, 4'b0110);
        // ---- branches
        exec_instr("b",     32'hEA00_0000, 32'h20, C_B, 4'hE, 1'b0, 1'b0, 4'hF, 32'h40,
                   1'b1, 1'b0, 1'b0, 32'h40, 4'b0110);
        exec_instr("bl",    32'hEB00_0000, 32'h40, C_B, 4'hE, 1'b1, 1'b1, 4'hF, 32'h100,
                   1'b1, 1'b0, 1'b1, 32'h100, 4'b0110);
        exec_instr("bx",    32'hE12F_FF10, 32'h100, C_BX, 4'hE, 1'b0, 1'b0, 4'h0, 32'h200,
                   1'b1, 1'b0, 1'b0, 32'h200, 4'b0110);
        exec_instr("eret",  32'hE160_006E, 32'h200, C_ERET, 4'hE, 1'b0, 1'b1, 4'h0, 32'hFFFF_FFFC,
                   1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 4'b0110);
        // ---- pc wrap
        exec_instr("wrap",  32'hE1A0_0000, 32'hFFFF_FFFC, C_MOV, 4'hE, 1'b0, 1'b0, 4'h0, 32'h0,
                   1'b1, 1'b1, 1'b0, 32'h0, 4'b0110);
        exec_instr("post",  32'hE1A0_0000, 32'h0, C_MOV, 4'hE, 1'b0, 1'b0, 4'h0, 32'h0,
                   1'b1, 1'b1, 1'b0, 32'h4, 4'b0110);

        // ---- undefined instruction
        fetch(32'hDEAD_BEEF, 1, 32'h4);
        set_dec(1'b0, 5'd0, 4'hE, 1'b0, 1'b0);
        tick();
        chk("trap_flag", {31'h0, trap}, 32'd1);
        chk("trap_state", {29'h0, state_o}, 32'd4);
        chk("trap_pc", pc, 32'h4);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            imem_ack  = i[0];
            dec_valid = ~i[0];
            tick();
            if (imem_req || cu_execute || rf_we || lr_we || state_o != 3'd4 || pc != 32'h4)
                bad++;
        end
        imem_ack = 1'b0;
        chk("trap_hold_bad_cycles", bad, 32'd0);
        chk("trap_ir", ir, 32'hDEAD_BEEF);
        rst = 1'b1;
        #1;
        chk("trap_rst_trap", {31'h0, trap}, 32'd0);
        chk("trap_rst_pc", pc, 32'h0);
        chk("trap_rst_state", {29'h0, state_o}, 32'd0);
        chk("trap_rst_req", {31'h0, imem_req}, 32'd0);
        tick();
        rst = 1'b0;
        set_dec(1'b1, 5'd0, 4'hE, 1'b0, 1'b0);
        tick();

        // ---- async reset in the middle of EXECUTE
        exec_instr("mov_f", 32'hE1B0_0000, 32'h0, C_MOV, 4'hE, 1'b1, 1'b0, 4'hF, 32'h0,
                   1'b1, 1'b1, 1'b0, 32'h4, 4'hF);
        fetch(32'hE1B0_0001, 0, 32'h4);
        set_dec(1'b1, C_MOV, 4'hE, 1'b1, 1'b0);
        set_alu(4'h5, 32'h0);
        tick();
        chk("ar_exe", {31'h0, cu_execute}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_exe_drop", {31'h0, cu_execute}, 32'd0);
        chk("ar_pc", pc, 32'h0);
        chk("ar_flags", flags4(), 32'h0);
        chk("ar_state", {29'h0, state_o}, 32'd0);
        chk("ar_req", {31'h0, imem_req}, 32'd0);
        tick();
        chk("ar_no_rf", {31'h0, rf_we}, 32'd0);
        rst = 1'b0;
        tick();
        chk("ar_no_rf2", {31'h0, rf_we}, 32'd0);
        chk("ar_req_back", {31'h0, imem_req}, 32'd1);
        chk("ar_addr", imem_addr, 32'h0);
        chk("ar_flags2", flags4(), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
